// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch stage ahead of the single-cycle datapath. Holds the PC,
// fetches one 32-bit word per req/ack transaction, and presents it with
// PC+4 over a valid/ready handshake. The next PC is resolved from the
// branch/zero/jump feedback sampled when the datapath consumes the word.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   imem_req/addr       fetch request and byte address (always pc)
//   imem_ack/rdata      memory response, only honoured while fetching
//   instr/pc_plus4      registered instruction and its PC+4
//   instr_valid/ready   handshake to the datapath
//   branch/zero/jump    control feedback for the consumed instruction
//   imm16/target26      branch word offset / jump target field
//   retired_count       instructions consumed since reset (wraps)
//
// state | meaning
// ------+------------------------------------------------------------
// WAIT  | out of reset, no request yet; any imem_ack is ignored
// FETCH | imem_req high at pc, waiting for imem_ack
// HOLD  | instr valid, waiting for instr_ready to retire it
module fetch_pc_unit #(
    parameter int               WIDTH    = 32,  // only 32 is supported
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    output logic [WIDTH-1:0] retired_count
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [WIDTH-1:0] p4;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] pc_next;

    assign p4        = pc_q + WIDTH'(4);
    // Word offset sign-extended and scaled to bytes.
    assign br_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        if (jump) begin
            // Jump keeps the 256 MB region of the sequential PC.
            pc_next = {p4[WIDTH-1:WIDTH-4], target26, 2'b00};
        end else if (branch && zero) begin
            pc_next = p4 + br_offset;
        end else begin
            pc_next = p4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            ST_WAIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + WIDTH'(1);
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_WAIT;
                valid_d = 1'b0;
            end
        endcase
        // Request is registered from the next state so it is already high
        // in the first FETCH cycle; a same-cycle ack is therefore legal.
        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign pc_plus4      = p4;
    assign instr_valid   = valid_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] retired_count;

    // Second instance starting at the top of the address space.
    logic        reset2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc_plus4_2;
    logic        valid2;
    logic        ready2;
    logic [31:0] count2;

    int tests_run = 0;
    int fails     = 0;
    int exp_count = 0;

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .jump(jump),
        .imm16(imm16), .target26(target26),
        .retired_count(retired_count)
    );

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset_n(reset2_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .instr(instr2), .pc_plus4(pc_plus4_2),
        .instr_valid(valid2), .instr_ready(ready2),
        .branch(1'b0), .zero(1'b0), .jump(1'b0),
        .imm16(16'h0000), .target26(26'h0),
        .retired_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Fetch one word, then consume it with the given feedback. Misleading
    // feedback is driven during the ack cycle; it must be ignored.
    task automatic run_instr(input logic [31:0] data, input logic b, input logic z,
                             input logic j, input logic [15:0] imm,
                             input logic [25:0] tgt, output bit ok);
        wait_req(ok);
        if (!ok) return;
        imem_ack = 1'b1; imem_rdata = data;
        jump = 1'b1; branch = 1'b1; zero = 1'b1; target26 = 26'h3FF_FFFF; imm16 = 16'h8000;
        tick();
        imem_ack = 1'b0;
        branch = b; zero = z; jump = j; imm16 = imm; target26 = tgt;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; imm16 = '0; target26 = '0;
        exp_count++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests_run++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            fails++; $display("FAIL reset_instr: got valid=%b instr=%h want 0/0", instr_valid, instr);
        end
        tests_run++;
        if (imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
            fails++; $display("FAIL reset_pc: got addr=%h p4=%h want 0/4", imem_addr, pc_plus4);
        end
        tests_run++;
        if (retired_count !== 32'h0) begin fails++; $display("FAIL reset_count: got %h want 0", retired_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = 32'(k * 4);
            wait_req(ok);
            tests_run++;
            if (!ok || imem_addr !== a) begin
                fails++; $display("FAIL seq_addr[%0d]: got req=%b addr=%h want 1/%h", k, ok, imem_addr, a);
            end
            imem_ack = 1'b1; imem_rdata = a ^ 32'hA5A5_0000;
            tick();
            imem_ack = 1'b0;
            tests_run++;
            if (instr !== (a ^ 32'hA5A5_0000) || instr_valid !== 1'b1 || pc_plus4 !== a + 32'd4) begin
                fails++; $display("FAIL seq_instr[%0d]: got instr=%h v=%b p4=%h want %h/1/%h",
                                  k, instr, instr_valid, pc_plus4, a ^ 32'hA5A5_0000, a + 32'd4);
            end
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            exp_count++;
            tests_run++;
            if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_valid_drop[%0d]: got %b want 0", k, instr_valid); end
        end
        tests_run++;
        if (retired_count !== 32'd4) begin fails++; $display("FAIL seq_count: got %0d want 4", retired_count); end
    endtask

    task automatic test_branch();
        bit ok;
        run_instr(32'h1111_0000, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, ok);
        wait_req(ok);
        tests_run++;
        if (!ok || imem_addr !== 32'h0000_000C) begin
            fails++; $display("FAIL branch_taken: got req=%b addr=%h want 1/0000000c", ok, imem_addr);
        end
        run_instr(32'h2222_0000, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, ok);
        run_instr(32'h3333_0000, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, ok);
        wait_req(ok);
        tests_run++;
        if (!ok || imem_addr !== 32'h0000_0014) begin
            fails++; $display("FAIL branch_not_taken: got req=%b addr=%h want 1/00000014", ok, imem_addr);
        end
    endtask

    task automatic test_jump();
        bit ok;
        run_instr(32'h4444_0000, 1'b0, 1'b0, 1'b1, 16'h0, 26'h10_0004, ok);
        wait_req(ok);
        tests_run++;
        if (!ok || imem_addr !== 32'h0040_0010) begin
            fails++; $display("FAIL jump_setup: got req=%b addr=%h want 1/00400010", ok, imem_addr);
        end
        run_instr(32'h5555_0000, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h100, ok);
        wait_req(ok);
        tests_run++;
        if (!ok || imem_addr !== 32'h0000_0400) begin
            fails++; $display("FAIL jump_priority: got req=%b addr=%h want 1/00000400", ok, imem_addr);
        end
    endtask

    task automatic test_hold_stable();
        bit ok;
        wait_req(ok);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rdata = 32'h0BAD_0BAD;  // stray ack held high during HOLD
        branch = 1'b1; zero = 1'b1; jump = 1'b1; target26 = 26'h155_5555;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (instr !== 32'hDEAD_BEEF || pc_plus4 !== 32'h0000_0404 || instr_valid !== 1'b1 ||
                imem_req !== 1'b0 || retired_count !== 32'(exp_count)) begin
                fails++; $display("FAIL hold_stable[%0d]: got instr=%h p4=%h v=%b req=%b cnt=%0d want deadbeef/00000404/1/0/%0d",
                                  c, instr, pc_plus4, instr_valid, imem_req, retired_count, exp_count);
            end
            tick();
        end
        imem_ack = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; target26 = '0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        exp_count++;
        tests_run++;
        if (retired_count !== 32'(exp_count) || imem_addr !== 32'h0000_0404) begin
            fails++; $display("FAIL hold_release: got cnt=%0d addr=%h want %0d/00000404", retired_count, imem_addr, exp_count);
        end
    endtask

    task automatic test_ready_no_valid();
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        tests_run++;
        if (retired_count !== 32'(exp_count) || imem_addr !== 32'h0000_0404 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL ready_no_valid: got cnt=%0d addr=%h v=%b req=%b want %0d/00000404/0/1",
                              retired_count, imem_addr, instr_valid, imem_req, exp_count);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || retired_count !== 32'h0 ||
            imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
            fails++; $display("FAIL mid_reset: got req=%b v=%b instr=%h cnt=%0d addr=%h p4=%h want 0/0/0/0/0/4",
                              imem_req, instr_valid, instr, retired_count, imem_addr, pc_plus4);
        end
        exp_count = 0;
        tick();
        tick();
        // Late ack lands while the unit is still in WAIT.
        imem_ack = 1'b1; imem_rdata = 32'hBAAD_F00D;
        reset_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        tests_run++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL stray_ack: got v=%b instr=%h req=%b addr=%h want 0/0/1/0",
                              instr_valid, instr, imem_req, imem_addr);
        end
        wait_req(ok);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        tests_run++;
        if (!ok || instr !== 32'h1234_5678 || instr_valid !== 1'b1) begin
            fails++; $display("FAIL post_reset_fetch: got instr=%h v=%b want 12345678/1", instr, instr_valid);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests_run++;
        if (retired_count !== 32'd1 || imem_addr !== 32'h4) begin
            fails++; $display("FAIL post_reset_consume: got cnt=%0d addr=%h want 1/00000004", retired_count, imem_addr);
        end
    endtask

    task automatic test_wrap();
        tests_run++;
        if (addr2 !== 32'hFFFF_FFFC || pc_plus4_2 !== 32'h0) begin
            fails++; $display("FAIL wrap_reset: got addr=%h p4=%h want fffffffc/0", addr2, pc_plus4_2);
        end
        reset2_n = 1'b1;
        tick();
        ack2 = 1'b1; rdata2 = 32'hCAFE_F00D;
        tick();
        ack2 = 1'b0;
        tests_run++;
        if (instr2 !== 32'hCAFE_F00D || valid2 !== 1'b1 || pc_plus4_2 !== 32'h0) begin
            fails++; $display("FAIL wrap_fetch: got instr=%h v=%b p4=%h want cafef00d/1/0", instr2, valid2, pc_plus4_2);
        end
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        tests_run++;
        if (addr2 !== 32'h0 || req2 !== 1'b1 || count2 !== 32'd1) begin
            fails++; $display("FAIL wrap_next: got addr=%h req=%b cnt=%0d want 0/1/1", addr2, req2, count2);
        end
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; imm16 = '0; target26 = '0;
        reset2_n = 1'b0; ack2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_hold_stable();
        test_ready_no_valid();
        test_reset_mid_fetch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
